// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, STEP bits per clock, borrow rippling across cycles.
// Optional SERSUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / STEP;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  generate
    if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_cfg
      $error("serial_subtractor: STEP must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   b_next;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   diff_q;
  logic               brw;
  logic               brw_n;
  logic               bout_q;
  logic [STEP:0]      chunk;
  logic [STEP-1:0]    d;
  logic               accept;
  logic               last;
  logic               busy;
  logic               done;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(NCHUNK - 1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One chunk of STEP bits: {brw', d} = a_lo - b_lo - brw in STEP+1-bit arithmetic.
  always_comb begin
    chunk = {1'b0, a_sh[STEP-1:0]} - {1'b0, b_sh[STEP-1:0]} - {{STEP{1'b0}}, brw};
    d     = chunk[STEP-1:0];
    brw_n = chunk[STEP];
  end

  // The minuend register doubles as the working result: each consumed chunk
  // frees STEP bits at the top, which receive the new difference chunk.
  generate
    if (STEP == WIDTH) begin : g_single
      always_comb begin
        a_next = d;
        b_next = '0;
      end
    end else begin : g_multi
      always_comb begin
        a_next = {d, a_sh[WIDTH-1:STEP]};
        b_next = b_sh >> STEP;
      end
    end
  endgenerate

`ifdef SERSUB_SAT_EN
  always_comb res = brw_n ? '0 : a_next;
`else
  always_comb res = a_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      brw  <= bus.bin;
      cnt  <= '0;
    end else if (busy) begin
      a_sh <= a_next;
      b_sh <= b_next;
      brw  <= brw_n;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        diff_q <= res;
        bout_q <= brw_n;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor across several WIDTH/STEP configurations.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   tests_run;
  int   fail_cnt;

  serial_subtractor_if #(.WIDTH(8)) if8s1 ();
  serial_subtractor_if #(.WIDTH(8)) if8s4 ();
  serial_subtractor_if #(.WIDTH(8)) if8s2 ();
  serial_subtractor_if #(.WIDTH(4)) if4s1 ();
  serial_subtractor_if #(.WIDTH(4)) if4s2 ();
  serial_subtractor_if #(.WIDTH(4)) if4s4 ();

  serial_subtractor #(.WIDTH(8), .STEP(1)) u8s1 (.clk(clk), .rst(rst), .bus(if8s1));
  serial_subtractor #(.WIDTH(8), .STEP(4)) u8s4 (.clk(clk), .rst(rst), .bus(if8s4));
  serial_subtractor #(.WIDTH(8), .STEP(2)) u8s2 (.clk(clk), .rst(rst), .bus(if8s2));
  serial_subtractor #(.WIDTH(4), .STEP(1)) u4s1 (.clk(clk), .rst(rst), .bus(if4s1));
  serial_subtractor #(.WIDTH(4), .STEP(2)) u4s2 (.clk(clk), .rst(rst), .bus(if4s2));
  serial_subtractor #(.WIDTH(4), .STEP(4)) u4s4 (.clk(clk), .rst(rst), .bus(if4s4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start u8s1 and wait (bounded) for done; lat is cycles from accept edge to done edge.
  task automatic go_8s1(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int bc);
    if8s1.a     = a;
    if8s1.b     = b;
    if8s1.bin   = bin;
    if8s1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s1.start = 1'b0;
    lat = -1;
    bc  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (if8s1.busy) bc++;
      if (if8s1.done) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat;
  int          bc;
  int          np;
  int          dk;
  logic [7:0]  sd;
  logic        sb;
  logic [4:0]  r4;
  logic [3:0]  e4;

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    rst = 1'b1;
    {if8s1.start, if8s1.a, if8s1.b, if8s1.bin} = '0;
    {if8s4.start, if8s4.a, if8s4.b, if8s4.bin} = '0;
    {if8s2.start, if8s2.a, if8s2.b, if8s2.bin} = '0;
    {if4s1.start, if4s1.a, if4s1.b, if4s1.bin} = '0;
    {if4s2.start, if4s2.a, if4s2.b, if4s2.bin} = '0;
    {if4s4.start, if4s4.a, if4s4.b, if4s4.bin} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 16'(if8s1.busy), 16'd0);
    check("rst_done", 16'(if8s1.done), 16'd0);
    check("rst_diff", 16'(if8s1.diff), 16'd0);
    check("rst_bout", 16'(if8s1.bout), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: 0x5A - 0x3C = 0x1E
    go_8s1(8'h5A, 8'h3C, 1'b0, lat, bc);
    check("t1_lat", 16'(lat), 16'd8);
    check("t1_busy_cycles", 16'(bc), 16'd8);
    check("t1_diff", 16'(if8s1.diff), 16'h1E);
    check("t1_bout", 16'(if8s1.bout), 16'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 16'(if8s1.done), 16'd0);
    check("t1_diff_hold", 16'(if8s1.diff), 16'h1E);

    // T2: 0x00 - 0x01 underflows
    go_8s1(8'h00, 8'h01, 1'b0, lat, bc);
    check("t2_lat", 16'(lat), 16'd8);
`ifdef SERSUB_SAT_EN
    check("t2_diff", 16'(if8s1.diff), 16'h00);
`else
    check("t2_diff", 16'(if8s1.diff), 16'hFF);
`endif
    check("t2_bout", 16'(if8s1.bout), 16'd1);
    @(negedge clk);

    // T4: start pulses and operand changes during RUN are ignored
    if8s1.a = 8'h33; if8s1.b = 8'h11; if8s1.bin = 1'b0; if8s1.start = 1'b1;
    @(posedge clk);
    np = 0;
    dk = 0;
    sd = '0;
    sb = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if8s1.start = (k == 3 || k == 5);
      if8s1.a = 8'hFF; if8s1.b = 8'h00; if8s1.bin = 1'b1;
      if (if8s1.done) begin
        np++;
        dk = k;
        sd = if8s1.diff;
        sb = if8s1.bout;
      end
    end
    if8s1.start = 1'b0;
    check("t4_done_pulses", 16'(np), 16'd1);
    check("t4_done_cycle", 16'(dk), 16'd9);
    check("t4_diff", 16'(sd), 16'h22);
    check("t4_bout", 16'(sb), 16'd0);
    check("t4_idle_after", 16'(if8s1.busy), 16'd0);

    // T3: STEP=4, 0x10 - 0x0F - 1 = 0, then back-to-back restart from DONE
    if8s4.a = 8'h10; if8s4.b = 8'h0F; if8s4.bin = 1'b1; if8s4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s4.start = 1'b0;
    check("t3_busy_k1", 16'(if8s4.busy), 16'd1);
    check("t3_done_k1", 16'(if8s4.done), 16'd0);
    @(negedge clk);
    check("t3_busy_k2", 16'(if8s4.busy), 16'd1);
    @(negedge clk);
    check("t3_done", 16'(if8s4.done), 16'd1);
    check("t3_busy_at_done", 16'(if8s4.busy), 16'd0);
    check("t3_diff", 16'(if8s4.diff), 16'h00);
    check("t3_bout", 16'(if8s4.bout), 16'd0);
    if8s4.a = 8'h01; if8s4.b = 8'h02; if8s4.bin = 1'b1; if8s4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s4.start = 1'b0;
    check("t3r_busy", 16'(if8s4.busy), 16'd1);
    check("t3r_done_low", 16'(if8s4.done), 16'd0);
    check("t3r_no_partial", 16'(if8s4.diff), 16'h00);
    @(negedge clk);
    @(negedge clk);
    check("t3r_done", 16'(if8s4.done), 16'd1);
`ifdef SERSUB_SAT_EN
    check("t3r_diff", 16'(if8s4.diff), 16'h00);
`else
    check("t3r_diff", 16'(if8s4.diff), 16'hFE);
`endif
    check("t3r_bout", 16'(if8s4.bout), 16'd1);
    @(negedge clk);
    check("t3r_idle", 16'({if8s4.busy, if8s4.done}), 16'd0);

    // T5: STEP=2, complete once, then reset mid-operation
    if8s2.a = 8'h80; if8s2.b = 8'h01; if8s2.bin = 1'b0; if8s2.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s2.start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_pre_done", 16'(if8s2.done), 16'd1);
    check("t5_pre_diff", 16'(if8s2.diff), 16'h7F);
    @(negedge clk);
    if8s2.a = 8'h55; if8s2.b = 8'h11; if8s2.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s2.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", 16'(if8s2.busy), 16'd0);
    check("t5_rst_done", 16'(if8s2.done), 16'd0);
    check("t5_rst_diff", 16'(if8s2.diff), 16'h00);
    check("t5_rst_bout", 16'(if8s2.bout), 16'd0);
    np = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if8s2.done || if8s2.busy) np++;
    end
    check("t5_discarded", 16'(np), 16'd0);
    rst = 1'b1;
    if8s2.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if8s2.start = 1'b0;
    check("t5_rst_wins", 16'(if8s2.busy), 16'd0);
    if8s2.a = 8'h45; if8s2.b = 8'h23; if8s2.bin = 1'b1; if8s2.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8s2.start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_new_done", 16'(if8s2.done), 16'd1);
    check("t5_new_diff", 16'(if8s2.diff), 16'h21);
    check("t5_new_bout", 16'(if8s2.bout), 16'd0);
    @(negedge clk);

    // T6: WIDTH=4 exhaustive, STEP 1/2/4 run side by side; u4s1 restarts from DONE
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          r4 = 5'(ai) - 5'(bi) - 5'(ci);
`ifdef SERSUB_SAT_EN
          e4 = r4[4] ? 4'h0 : r4[3:0];
`else
          e4 = r4[3:0];
`endif
          {if4s1.a, if4s1.b, if4s1.bin} = {4'(ai), 4'(bi), 1'(ci)};
          {if4s2.a, if4s2.b, if4s2.bin} = {4'(ai), 4'(bi), 1'(ci)};
          {if4s4.a, if4s4.b, if4s4.bin} = {4'(ai), 4'(bi), 1'(ci)};
          if4s1.start = 1'b1; if4s2.start = 1'b1; if4s4.start = 1'b1;
          @(posedge clk);
          @(negedge clk);
          if4s1.start = 1'b0; if4s2.start = 1'b0; if4s4.start = 1'b0;
          for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) check("t6_s4", 16'({if4s4.done, if4s4.bout, if4s4.diff}), 16'({1'b1, r4[4], e4}));
            if (k == 3) check("t6_s2", 16'({if4s2.done, if4s2.bout, if4s2.diff}), 16'({1'b1, r4[4], e4}));
            if (k == 5) check("t6_s1", 16'({if4s1.done, if4s1.bout, if4s1.diff}), 16'({1'b1, r4[4], e4}));
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
